enemy_controller: RTL and testbench
===================================

# enemy_controller

Owns the five enemy slots: per-enemy hit points, hit stun, death, respawn timing and chase movement toward the player. Sits directly downstream of the game-state block: it consumes the per-enemy damage strobes and game-over flag that block produces, and it generates the Enemy1..5 X/Y coordinates that block, and the sprite renderer, read back. Everything advances once per frame on Frame_clk.

## Interface
- ENEMY_HP, 2: hit points per enemy at spawn/respawn (1..3).
- HIT_INVULN, 30: frames spent in STUNNED after a non-lethal hit.
- RESPAWN_DELAY, 120: frames spent in DEAD before respawn.
- MOVE_DIV, 2: enemies move once every MOVE_DIV frames (1..15).
- STEP, 1: pixels moved per axis per move tick.
- X_MAX, 608 / Y_MAX, 448: maximum top-left coordinate (32 px sprite on 640x480).
- PARK_XY, 1000: coordinate driven on both axes while DEAD (off-screen).

Ports:
- Frame_clk  in  1  frame-rate clock.
- Reset  in  1  synchronous, active-high.
- Damage_E1..Damage_E5  in  1 each  level "enemy n is hit this frame".
- game_over  in  1  level; re-initialises all slots while high.
- Player_X, Player_Y  in  10 each  player top-left, unsigned.
- Enemy1_X..Enemy5_X, Enemy1_Y..Enemy5_Y  out  10 each  registered enemy coordinates.
- Enemy_Alive  out  5  bit n-1 = enemy n is ALIVE or STUNNED.
- Enemy_Stunned  out  5  bit n-1 = enemy n is STUNNED (renderer flashes it).
- Kill_Pulse  out  1  high for exactly one frame when at least one enemy enters DEAD.

## Operation
- Fixed spawn points: E1 (64,64), E2 (576,64), E3 (64,416), E4 (576,416), E5 (320,64).
- Per-slot FSM, states ALIVE, STUNNED, DEAD. Each slot has a 2-bit hp and a 7-bit frame timer.
- Reset or game_over (Reset wins if both are high): every slot goes to ALIVE at its spawn point, hp=ENEMY_HP, timer=0. Also Enemy_Alive=5'b11111, Enemy_Stunned=0, Kill_Pulse=0, move divider=0.
- ALIVE with Damage_En=1:
  - if hp>1: hp-=1, go to STUNNED, timer=HIT_INVULN-1.
  - if hp<=1: hp=0, go to DEAD, timer=RESPAWN_DELAY-1, coordinates=PARK_XY.
- STUNNED: Damage_En is ignored. Position is held. When timer==0, go to ALIVE; otherwise decrement the timer.
- DEAD: Damage_En is ignored. Coordinates stay at PARK_XY. When timer==0, go to ALIVE at the spawn point with hp=ENEMY_HP; otherwise decrement the timer.
- Because damage is a level, a hit held high for many frames costs exactly one hp per stun window.
- Movement:
  - A global divider counts 0..MOVE_DIV-1; a move tick occurs on the frame it reads MOVE_DIV-1.
  - On a tick, each ALIVE slot not damaged this frame updates each axis independently, unsigned compare:
    - pos < player: pos = min(pos+STEP, player, X_MAX/Y_MAX).
    - pos > player: pos = max(pos-STEP, player).
    - equal: hold.
  - Arithmetic uses 11 bits internally and the result is truncated after clamping, so there is no wrap-around.
- Kill_Pulse is the OR over slots of the ALIVE->DEAD transition, registered.
- All five slots are evaluated in parallel. Simultaneous damage on several enemies is handled independently, with no priority.

## Timing
- All outputs are registered. Damage sampled at edge k is reflected in state, coordinates, Enemy_Alive, Enemy_Stunned and Kill_Pulse after edge k.
- STUNNED lasts exactly HIT_INVULN frames. DEAD lasts exactly RESPAWN_DELAY frames, then the slot appears at its spawn point on the next frame.
- With MOVE_DIV=2 an enemy moves at most STEP px per axis every 2nd frame. The first tick after reset is the 2nd edge.
- Reset or game_over mid-stun or mid-death aborts the timer immediately: on the next edge the slot is ALIVE at spawn.

## Test plan
- Reset: assert Reset 1 frame -> Enemy1=(64,64), Enemy5=(320,64), Enemy_Alive=11111, Enemy_Stunned=0, Kill_Pulse=0.
- Hit with default params: hold Damage_E1 high for 40 frames -> hp 2->1 after the first frame, Enemy_Stunned[0]=1 for exactly 30 frames, then one more hit -> DEAD, Kill_Pulse=1 for one frame, Enemy1=(1000,1000), Enemy_Alive[0]=0.
- Respawn: after E1 dies, drop damage -> Enemy_Alive[0] returns to 1 exactly 120 frames later, with Enemy1=(64,64) and hp=2 (two more hits are needed to kill it).
- Chase: Player=(100,64), E1 at (64,64), no damage -> after 8 frames Enemy1_X=68 and Y stays 64. Player=(65,64) -> X stops at 65 with no overshoot.
- Clamp: Player=(620,470), E4 at (576,416) -> after enough frames Enemy4 saturates at (608,448).
- Simultaneous / abort: all five damage inputs high for 1 frame -> all five STUNNED and Kill_Pulse=0. Then game_over pulsed mid-stun -> all ALIVE at spawn on the next frame.

Source files
------------

// File: rtl/enemy_controller.sv
`default_nettype none
// ============================================================================
// Module   : enemy_controller
// Purpose  : Five enemy slots with hp, hit stun, death/respawn and player chase.
// Revision : 1.0 - initial release
// ============================================================================
module enemy_controller #(
   parameter int ENEMY_HP      = 2,
   parameter int HIT_INVULN    = 30,
   parameter int RESPAWN_DELAY = 120,
   parameter int MOVE_DIV      = 2,
   parameter int STEP          = 1,
   parameter int X_MAX         = 608,
   parameter int Y_MAX         = 448,
   parameter int PARK_XY       = 1000
) (
   input  logic       Frame_clk,
   input  logic       Reset,
   input  logic       Damage_E1,
   input  logic       Damage_E2,
   input  logic       Damage_E3,
   input  logic       Damage_E4,
   input  logic       Damage_E5,
   input  logic       game_over,
   input  logic [9:0] Player_X,
   input  logic [9:0] Player_Y,
   output logic [9:0] Enemy1_X,
   output logic [9:0] Enemy1_Y,
   output logic [9:0] Enemy2_X,
   output logic [9:0] Enemy2_Y,
   output logic [9:0] Enemy3_X,
   output logic [9:0] Enemy3_Y,
   output logic [9:0] Enemy4_X,
   output logic [9:0] Enemy4_Y,
   output logic [9:0] Enemy5_X,
   output logic [9:0] Enemy5_Y,
   output logic [4:0] Enemy_Alive,
   output logic [4:0] Enemy_Stunned,
   output logic       Kill_Pulse
);

   typedef enum logic [1:0] {
      ST_ALIVE   = 2'd0,
      ST_STUNNED = 2'd1,
      ST_DEAD    = 2'd2
   } state_t;

   localparam logic [1:0]  c_hp_init   = 2'(ENEMY_HP);
   localparam logic [6:0]  c_stun_init = 7'(HIT_INVULN - 1);
   localparam logic [6:0]  c_dead_init = 7'(RESPAWN_DELAY - 1);
   localparam logic [9:0]  c_park      = 10'(PARK_XY);
   localparam logic [10:0] c_step      = 11'(STEP);
   localparam logic [10:0] c_x_max     = 11'(X_MAX);
   localparam logic [10:0] c_y_max     = 11'(Y_MAX);
   localparam logic [3:0]  c_div_last  = 4'(MOVE_DIV - 1);

   logic        w_init;
   logic        w_tick;
   logic [3:0]  r_div;
   logic [4:0]  w_damage;
   logic [4:0]  w_alive_nxt;
   logic [4:0]  w_stun_nxt;
   logic [4:0]  w_kill;
   logic [49:0] w_pos_x;
   logic [49:0] w_pos_y;

   assign w_init   = Reset | game_over;
   assign w_tick   = (r_div == c_div_last);
   assign w_damage = {Damage_E5, Damage_E4, Damage_E3, Damage_E2, Damage_E1};

   // One chase step on one axis; 11-bit math so neither direction can wrap.
   function automatic logic [9:0] chase(input logic [9:0] pos, input logic [9:0] target,
                                         input logic [10:0] lim);
      logic [10:0] p;
      logic [10:0] t;
      logic [10:0] r;
      p = {1'b0, pos};
      t = {1'b0, target};
      r = p;
      if (p < t) begin
         r = ((t - p) <= c_step) ? t : (p + c_step);
         if (r > lim) r = lim;
      end else if (p > t) begin
         r = ((p - t) <= c_step) ? t : (p - c_step);
      end
      return 10'(r);
   endfunction

   for (genvar i = 0; i < 5; i++) begin : g_slot
      localparam logic [9:0] c_spawn_x = (i == 1 || i == 3) ? 10'd576 :
                                         (i == 4)           ? 10'd320 : 10'd64;
      localparam logic [9:0] c_spawn_y = (i == 2 || i == 3) ? 10'd416 : 10'd64;

      state_t     r_state;
      state_t     w_state_nxt;
      logic [1:0] r_hp;
      logic [1:0] w_hp_nxt;
      logic [6:0] r_timer;
      logic [6:0] w_timer_nxt;
      logic [9:0] r_x;
      logic [9:0] r_y;
      logic [9:0] w_x_nxt;
      logic [9:0] w_y_nxt;
      logic       w_kill_slot;

      always_comb begin
         w_state_nxt = r_state;
         w_hp_nxt    = r_hp;
         w_timer_nxt = r_timer;
         w_x_nxt     = r_x;
         w_y_nxt     = r_y;
         w_kill_slot = 1'b0;
         case (r_state)
            ST_ALIVE: begin
               if (w_damage[i]) begin
                  if (r_hp > 2'd1) begin
                     w_hp_nxt    = r_hp - 2'd1;
                     w_state_nxt = ST_STUNNED;
                     w_timer_nxt = c_stun_init;
                  end else begin
                     w_hp_nxt    = 2'd0;
                     w_state_nxt = ST_DEAD;
                     w_timer_nxt = c_dead_init;
                     w_x_nxt     = c_park;
                     w_y_nxt     = c_park;
                     w_kill_slot = 1'b1;
                  end
               end else if (w_tick) begin
                  w_x_nxt = chase(r_x, Player_X, c_x_max);
                  w_y_nxt = chase(r_y, Player_Y, c_y_max);
               end
            end
            ST_STUNNED: begin
               if (r_timer == 7'd0) w_state_nxt = ST_ALIVE;
               else                 w_timer_nxt = r_timer - 7'd1;
            end
            ST_DEAD: begin
               if (r_timer == 7'd0) begin
                  w_state_nxt = ST_ALIVE;
                  w_hp_nxt    = c_hp_init;
                  w_x_nxt     = c_spawn_x;
                  w_y_nxt     = c_spawn_y;
               end else begin
                  w_timer_nxt = r_timer - 7'd1;
               end
            end
            default: w_state_nxt = ST_ALIVE;
         endcase
      end

      always_ff @(posedge Frame_clk) begin
         if (w_init) begin
            r_state <= ST_ALIVE;
            r_hp    <= c_hp_init;
            r_timer <= 7'd0;
            r_x     <= c_spawn_x;
            r_y     <= c_spawn_y;
         end else begin
            r_state <= w_state_nxt;
            r_hp    <= w_hp_nxt;
            r_timer <= w_timer_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
         end
      end

      assign w_pos_x[i*10 +: 10] = r_x;
      assign w_pos_y[i*10 +: 10] = r_y;
      assign w_alive_nxt[i]      = (w_state_nxt != ST_DEAD);
      assign w_stun_nxt[i]       = (w_state_nxt == ST_STUNNED);
      assign w_kill[i]           = w_kill_slot;
   end

   always_ff @(posedge Frame_clk) begin
      if (w_init) begin
         r_div         <= 4'd0;
         Enemy_Alive   <= 5'b11111;
         Enemy_Stunned <= 5'b00000;
         Kill_Pulse    <= 1'b0;
      end else begin
         r_div         <= w_tick ? 4'd0 : (r_div + 4'd1);
         Enemy_Alive   <= w_alive_nxt;
         Enemy_Stunned <= w_stun_nxt;
         Kill_Pulse    <= |w_kill;
      end
   end

   assign Enemy1_X = w_pos_x[9:0];
   assign Enemy1_Y = w_pos_y[9:0];
   assign Enemy2_X = w_pos_x[19:10];
   assign Enemy2_Y = w_pos_y[19:10];
   assign Enemy3_X = w_pos_x[29:20];
   assign Enemy3_Y = w_pos_y[29:20];
   assign Enemy4_X = w_pos_x[39:30];
   assign Enemy4_Y = w_pos_y[39:30];
   assign Enemy5_X = w_pos_x[49:40];
   assign Enemy5_Y = w_pos_y[49:40];

endmodule
`default_nettype wire

// File: tb/tb_enemy_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_enemy_controller
// Purpose  : Directed stimulus with an expected-value queue drained by a monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_enemy_controller;

   logic       Frame_clk = 1'b0;
   logic       Reset;
   logic       Damage_E1, Damage_E2, Damage_E3, Damage_E4, Damage_E5;
   logic       game_over;
   logic [9:0] Player_X, Player_Y;
   logic [9:0] Enemy1_X, Enemy1_Y, Enemy2_X, Enemy2_Y, Enemy3_X, Enemy3_Y;
   logic [9:0] Enemy4_X, Enemy4_Y, Enemy5_X, Enemy5_Y;
   logic [4:0] Enemy_Alive, Enemy_Stunned;
   logic       Kill_Pulse;

   always #5 Frame_clk = ~Frame_clk;

   enemy_controller dut (
      .Frame_clk    (Frame_clk),
      .Reset        (Reset),
      .Damage_E1    (Damage_E1),
      .Damage_E2    (Damage_E2),
      .Damage_E3    (Damage_E3),
      .Damage_E4    (Damage_E4),
      .Damage_E5    (Damage_E5),
      .game_over    (game_over),
      .Player_X     (Player_X),
      .Player_Y     (Player_Y),
      .Enemy1_X     (Enemy1_X),
      .Enemy1_Y     (Enemy1_Y),
      .Enemy2_X     (Enemy2_X),
      .Enemy2_Y     (Enemy2_Y),
      .Enemy3_X     (Enemy3_X),
      .Enemy3_Y     (Enemy3_Y),
      .Enemy4_X     (Enemy4_X),
      .Enemy4_Y     (Enemy4_Y),
      .Enemy5_X     (Enemy5_X),
      .Enemy5_Y     (Enemy5_Y),
      .Enemy_Alive  (Enemy_Alive),
      .Enemy_Stunned(Enemy_Stunned),
      .Kill_Pulse   (Kill_Pulse)
   );

   localparam int c_e1x = 0, c_e1y = 1, c_e4x = 2, c_e4y = 3, c_e5x = 4;
   localparam int c_alive = 5, c_stun = 6, c_kill = 7;

   typedef struct {
      int tgt;
      int code;
      int val;
   } exp_t;

   exp_t q[$];
   exp_t m_e;
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   always @(posedge Frame_clk) cyc <= cyc + 1;

   function automatic int sig(input int code);
      case (code)
         c_e1x:   return int'(Enemy1_X);
         c_e1y:   return int'(Enemy1_Y);
         c_e4x:   return int'(Enemy4_X);
         c_e4y:   return int'(Enemy4_Y);
         c_e5x:   return int'(Enemy5_X);
         c_alive: return int'(Enemy_Alive);
         c_stun:  return int'(Enemy_Stunned);
         default: return int'(Kill_Pulse);
      endcase
   endfunction

   function automatic string sname(input int code);
      case (code)
         c_e1x:   return "Enemy1_X";
         c_e1y:   return "Enemy1_Y";
         c_e4x:   return "Enemy4_X";
         c_e4y:   return "Enemy4_Y";
         c_e5x:   return "Enemy5_X";
         c_alive: return "Enemy_Alive";
         c_stun:  return "Enemy_Stunned";
         default: return "Kill_Pulse";
      endcase
   endfunction

   // Expected value of an output as it stands after the next rising edge.
   task automatic push_exp(input int code, input int val);
      exp_t e;
      e.tgt  = cyc + 1;
      e.code = code;
      e.val  = val;
      q.push_back(e);
   endtask

   task automatic frame();
      @(negedge Frame_clk);
   endtask

   always @(negedge Frame_clk) begin
      while (q.size() > 0 && q[0].tgt <= cyc) begin
         m_e    = q.pop_front();
         checks = checks + 1;
         if (m_e.tgt != cyc) begin
            errors = errors + 1;
            $display("FAIL %s: check for edge %0d not reached in time (now %0d)",
                     sname(m_e.code), m_e.tgt, cyc);
         end else if (sig(m_e.code) != m_e.val) begin
            errors = errors + 1;
            $display("FAIL %s @edge %0d: got %0d, expected %0d",
                     sname(m_e.code), cyc, sig(m_e.code), m_e.val);
         end
      end
   end

   initial begin
      Reset     = 1'b1;
      game_over = 1'b0;
      {Damage_E5, Damage_E4, Damage_E3, Damage_E2, Damage_E1} = 5'b0;
      Player_X  = 10'd64;
      Player_Y  = 10'd64;
      frame();

      // Reset state
      push_exp(c_e1x, 64);
      push_exp(c_e1y, 64);
      push_exp(c_e5x, 320);
      push_exp(c_alive, 5'b11111);
      push_exp(c_stun, 0);
      push_exp(c_kill, 0);
      frame();
      Reset = 1'b0;

      // Held hit, death, respawn, then two further hits to kill again
      for (int e = 1; e <= 185; e++) begin
         Damage_E1 = (e <= 40) || (e == 153) || (e == 184);
         push_exp(c_stun, ((e <= 30) || (e >= 153 && e <= 182)) ? 1 : 0);
         push_exp(c_alive, ((e >= 32 && e <= 151) || (e >= 184)) ? 5'b11110 : 5'b11111);
         push_exp(c_kill, ((e == 32) || (e == 184)) ? 1 : 0);
         if (e == 32 || e == 151 || e == 184) begin
            push_exp(c_e1x, 1000);
            push_exp(c_e1y, 1000);
         end
         if (e == 152) begin
            push_exp(c_e1x, 64);
            push_exp(c_e1y, 64);
         end
         frame();
      end
      Damage_E1 = 1'b0;

      // Chase toward (100,64), then back to (65,64) without overshoot
      Reset    = 1'b1;
      Player_X = 10'd100;
      push_exp(c_alive, 5'b11111);
      push_exp(c_e1x, 64);
      frame();
      Reset = 1'b0;
      for (int e = 1; e <= 16; e++) begin
         if (e == 9) Player_X = 10'd65;
         if (e <= 8) push_exp(c_e1x, 64 + e / 2);
         else        push_exp(c_e1x, ((68 - (e - 8) / 2) > 65) ? (68 - (e - 8) / 2) : 65);
         push_exp(c_e1y, 64);
         if (e == 8) push_exp(c_e5x, 316);
         frame();
      end

      // Saturation at the bottom-right limit
      Reset    = 1'b1;
      Player_X = 10'd620;
      Player_Y = 10'd470;
      frame();
      Reset = 1'b0;
      for (int e = 1; e <= 80; e++) begin
         if (e == 2)  begin push_exp(c_e4x, 577); push_exp(c_e4y, 417); end
         if (e == 62) begin push_exp(c_e4x, 607); push_exp(c_e4y, 447); end
         if (e == 64 || e == 80) begin push_exp(c_e4x, 608); push_exp(c_e4y, 448); end
         frame();
      end

      // Simultaneous hits, then game_over aborts the stun
      Reset    = 1'b1;
      Player_X = 10'd64;
      Player_Y = 10'd64;
      frame();
      Reset = 1'b0;
      {Damage_E5, Damage_E4, Damage_E3, Damage_E2, Damage_E1} = 5'b11111;
      push_exp(c_stun, 5'b11111);
      push_exp(c_alive, 5'b11111);
      push_exp(c_kill, 0);
      frame();
      {Damage_E5, Damage_E4, Damage_E3, Damage_E2, Damage_E1} = 5'b0;
      push_exp(c_stun, 5'b11111);
      push_exp(c_e4x, 576);
      frame();
      game_over = 1'b1;
      push_exp(c_stun, 0);
      push_exp(c_alive, 5'b11111);
      push_exp(c_e4x, 576);
      push_exp(c_e4y, 416);
      push_exp(c_e5x, 320);
      push_exp(c_kill, 0);
      frame();
      game_over = 1'b0;
      push_exp(c_stun, 0);
      frame();
      frame();
      frame();

      if (q.size() != 0) begin
         errors = errors + 1;
         $display("FAIL drain: %0d expectations left, expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      errors = errors + 1;
      $display("FAIL timeout: cycle %0d, expected completion before 20000", cyc);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
